// File: rtl/crm_slice_p_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | crm_slice_p_if : diag/CRA/EBUS bundle for the parametrised CRAM slice    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface crm_slice_p_if #(
  parameter int ADDR_W  = 11,
  parameter int NFUNC   = 4,
  parameter int FIELD_W = 4
);
  localparam int FSEL_W = (NFUNC > 1) ? $clog2(NFUNC) : 1;
  localparam int W      = NFUNC * FIELD_W;

  logic [ADDR_W-1:0]  cra_adr_h;
  logic               diag_load_l;
  logic               diag_read_l;
  logic [FSEL_W-1:0]  diag_func_h;
  logic [FIELD_W-1:0] diag_data_h;
  logic [W-1:0]       cram_word_h;
  logic               cram_par_h;
  logic [FIELD_W-1:0] ebus_d_h;
  logic               ebus_oe_h;
  logic               diag_busy_h;
  logic               cram_par_err_h;

  modport master (
    output cra_adr_h, diag_load_l, diag_read_l, diag_func_h, diag_data_h,
    input  cram_word_h, cram_par_h, ebus_d_h, ebus_oe_h, diag_busy_h, cram_par_err_h
  );

  modport slave (
    input  cra_adr_h, diag_load_l, diag_read_l, diag_func_h, diag_data_h,
    output cram_word_h, cram_par_h, ebus_d_h, ebus_oe_h, diag_busy_h, cram_par_err_h
  );
endinterface
`default_nettype wire

// File: rtl/crm_slice_p.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | crm_slice_p : parametrised control-RAM slice with staged diag commit     |
// | Option macro: CRM_PARITY_CHECK_EN (stored parity bit + sticky error)     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module crm_slice_p #(
  parameter int ADDR_W  = 11,
  parameter int NFUNC   = 4,
  parameter int FIELD_W = 4
) (
  input  wire logic     clk_crm_h,
  input  wire logic     mr_reset_l,
  crm_slice_p_if.slave  bus
);
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int W      = NFUNC * FIELD_W;
  localparam int FSEL_W = (NFUNC > 1) ? $clog2(NFUNC) : 1;
`ifdef CRM_PARITY_CHECK_EN
  localparam int RAM_W  = W + 1;
`else
  localparam int RAM_W  = W;
`endif
  localparam logic [FSEL_W-1:0] c_LAST = FSEL_W'(NFUNC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STAGE  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t             r_state;
  logic [W-1:0]       r_stage;
  logic [W-1:0]       r_word;
  logic               r_busy;
  logic               r_oe;
  logic [FIELD_W-1:0] r_ebus;
  logic [RAM_W-1:0]   r_ram [DEPTH];

  logic               w_commit;
  logic               w_load;
  logic               w_func_ok;
  logic [FIELD_W-1:0] w_rd_field;
  logic [RAM_W-1:0]   w_wr_data;
  logic [RAM_W-1:0]   w_rd_data;

  assign w_commit  = (r_state == COMMIT);
  assign w_load    = ~bus.diag_load_l & ~w_commit;
  assign w_rd_data = r_ram[bus.cra_adr_h];

`ifdef CRM_PARITY_CHECK_EN
  assign w_wr_data = {~^r_stage, r_stage};
`else
  assign w_wr_data = r_stage;
`endif

  // Decoded field select: also yields the range check and a zero field for
  // out-of-range indices when NFUNC is not a power of two.
  always_comb begin
    w_func_ok  = 1'b0;
    w_rd_field = '0;
    for (int i = 0; i < NFUNC; i++) begin
      if (bus.diag_func_h == FSEL_W'(i)) begin
        w_func_ok  = 1'b1;
        w_rd_field = r_word[i*FIELD_W +: FIELD_W];
      end
    end
  end

  always_ff @(posedge clk_crm_h or negedge mr_reset_l) begin
    if (!mr_reset_l) begin
      r_state <= IDLE;
      r_stage <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        COMMIT: begin
          r_state <= IDLE;
          r_stage <= '0;
          r_busy  <= 1'b0;
        end
        default: begin
          if (w_load && w_func_ok) begin
            for (int i = 0; i < NFUNC; i++) begin
              if (bus.diag_func_h == FSEL_W'(i))
                r_stage[i*FIELD_W +: FIELD_W] <= bus.diag_data_h;
            end
            if (bus.diag_func_h == c_LAST) begin
              r_state <= COMMIT;
              r_busy  <= 1'b1;
            end else begin
              r_state <= STAGE;
            end
          end
        end
      endcase
    end
  end

  // Storage array has no reset; contents survive mr_reset_l.
  always_ff @(posedge clk_crm_h) begin
    if (w_commit)
      r_ram[bus.cra_adr_h] <= w_wr_data;
  end

  // Read and write share one address, so a commit always forwards the new word.
  always_ff @(posedge clk_crm_h or negedge mr_reset_l) begin
    if (!mr_reset_l)
      r_word <= '0;
    else
      r_word <= w_commit ? r_stage : w_rd_data[W-1:0];
  end

  always_ff @(posedge clk_crm_h or negedge mr_reset_l) begin
    if (!mr_reset_l) begin
      r_oe   <= 1'b0;
      r_ebus <= '0;
    end else if (!bus.diag_load_l) begin
      r_oe   <= 1'b0;
      r_ebus <= '0;
    end else if (!bus.diag_read_l) begin
      r_oe   <= 1'b1;
      r_ebus <= w_rd_field;
    end else begin
      r_oe   <= 1'b0;
      r_ebus <= '0;
    end
  end

`ifdef CRM_PARITY_CHECK_EN
  logic r_par_st;
  logic r_chk_en;
  logic r_par_err;

  // r_chk_en masks the first edge after reset, when r_word is not RAM data.
  always_ff @(posedge clk_crm_h or negedge mr_reset_l) begin
    if (!mr_reset_l) begin
      r_par_st  <= 1'b1;
      r_chk_en  <= 1'b0;
      r_par_err <= 1'b0;
    end else begin
      r_par_st  <= w_commit ? ~^r_stage : w_rd_data[W];
      r_chk_en  <= 1'b1;
      if (r_chk_en && (r_par_st != ~^r_word))
        r_par_err <= 1'b1;
    end
  end

  assign bus.cram_par_err_h = r_par_err;
`else
  assign bus.cram_par_err_h = 1'b0;
`endif

  assign bus.cram_word_h = r_word;
  assign bus.cram_par_h  = ~^r_word;
  assign bus.ebus_d_h    = r_ebus;
  assign bus.ebus_oe_h   = r_oe;
  assign bus.diag_busy_h = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_crm_slice_p.sv
`default_nettype none
// Self-checking bench for crm_slice_p: directed scenarios plus a randomized
// run against a transaction-level model of the staging/commit/readback rules.
module tb_crm_slice_p;
  localparam int ADDR_W  = 11;
  localparam int NFUNC   = 4;
  localparam int FIELD_W = 4;
  localparam int W       = NFUNC * FIELD_W;
  localparam int FSEL_W  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  crm_slice_p_if #(.ADDR_W(ADDR_W), .NFUNC(NFUNC), .FIELD_W(FIELD_W)) bus ();

  crm_slice_p #(.ADDR_W(ADDR_W), .NFUNC(NFUNC), .FIELD_W(FIELD_W)) dut (
    .clk_crm_h  (clk),
    .mr_reset_l (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.diag_load_l = 1'b1;
    bus.diag_read_l = 1'b1;
    bus.diag_func_h = '0;
    bus.diag_data_h = '0;
  endtask

  task automatic load(input int f, input logic [FIELD_W-1:0] d);
    bus.diag_load_l = 1'b0;
    bus.diag_func_h = FSEL_W'(f);
    bus.diag_data_h = d;
  endtask

  task automatic test_reset();
    idle();
    bus.cra_adr_h = '0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (bus.cram_word_h !== '0) begin bad++; $display("FAIL rst_word got=%h exp=0", bus.cram_word_h); end
    total++; if (bus.cram_par_h !== 1'b1) begin bad++; $display("FAIL rst_par got=%b exp=1", bus.cram_par_h); end
    total++; if (bus.ebus_oe_h !== 1'b0) begin bad++; $display("FAIL rst_oe got=%b exp=0", bus.ebus_oe_h); end
    total++; if (bus.ebus_d_h !== '0) begin bad++; $display("FAIL rst_ebus got=%h exp=0", bus.ebus_d_h); end
    total++; if (bus.diag_busy_h !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.diag_busy_h); end
    total++; if (bus.cram_par_err_h !== 1'b0) begin bad++; $display("FAIL rst_parerr got=%b exp=0", bus.cram_par_err_h); end
    rst_n = 1'b1;
    #1;
    total++; if (bus.diag_busy_h !== 1'b0) begin bad++; $display("FAIL rel_busy got=%b exp=0", bus.diag_busy_h); end
    total++; if (bus.cram_par_h !== 1'b1) begin bad++; $display("FAIL rel_par got=%b exp=1", bus.cram_par_h); end
  endtask

  task automatic test_commit_basic();
    bus.cra_adr_h = 11'h005;
    for (int f = 0; f < NFUNC; f++) begin
      load(f, FIELD_W'(f + 1));
      step();
    end
    idle();
    total++; if (bus.diag_busy_h !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", bus.diag_busy_h); end
    step();
    total++; if (bus.cram_word_h !== 16'h4321) begin bad++; $display("FAIL basic_word got=%h exp=4321", bus.cram_word_h); end
    total++; if (bus.cram_par_h !== 1'b0) begin bad++; $display("FAIL basic_par got=%b exp=0", bus.cram_par_h); end
    total++; if (bus.diag_busy_h !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b exp=0", bus.diag_busy_h); end
  endtask

  task automatic test_partial_readback();
    logic [FIELD_W-1:0] exp_d;
    bus.cra_adr_h = 11'h7FF;
    load(3, 4'hF);
    step();
    idle();
    total++; if (bus.diag_busy_h !== 1'b1) begin bad++; $display("FAIL part_busy got=%b exp=1", bus.diag_busy_h); end
    step();
    total++; if (bus.cram_word_h !== 16'hF000) begin bad++; $display("FAIL part_word got=%h exp=f000", bus.cram_word_h); end
    for (int f = 0; f < NFUNC; f++) begin
      bus.diag_read_l = 1'b0;
      bus.diag_func_h = FSEL_W'(f);
      step();
      exp_d = (f == 3) ? 4'hF : 4'h0;
      total++; if (bus.ebus_oe_h !== 1'b1) begin bad++; $display("FAIL rb_oe f=%0d got=%b exp=1", f, bus.ebus_oe_h); end
      total++; if (bus.ebus_d_h !== exp_d) begin bad++; $display("FAIL rb_data f=%0d got=%h exp=%h", f, bus.ebus_d_h, exp_d); end
    end
    idle();
    step();
    total++; if (bus.ebus_oe_h !== 1'b0) begin bad++; $display("FAIL rb_rel_oe got=%b exp=0", bus.ebus_oe_h); end
    total++; if (bus.ebus_d_h !== '0) begin bad++; $display("FAIL rb_rel_data got=%h exp=0", bus.ebus_d_h); end
  endtask

  task automatic test_load_during_commit();
    bus.cra_adr_h = 11'h008;
    for (int f = 0; f < NFUNC; f++) begin
      load(f, FIELD_W'(4'hA + f));
      step();
    end
    load(1, 4'h7);
    step();
    idle();
    total++; if (bus.cram_word_h !== 16'hDCBA) begin bad++; $display("FAIL ldc_word got=%h exp=dcba", bus.cram_word_h); end
    total++; if (bus.diag_busy_h !== 1'b0) begin bad++; $display("FAIL ldc_busy got=%b exp=0", bus.diag_busy_h); end
    load(3, 4'h1);
    step();
    idle();
    step();
    total++; if (bus.cram_word_h !== 16'h1000) begin bad++; $display("FAIL ldc_drop got=%h exp=1000", bus.cram_word_h); end
  endtask

  task automatic test_load_read_conflict();
    bus.cra_adr_h = 11'h7FF;
    idle();
    step();
    bus.diag_read_l = 1'b0;
    load(0, 4'h5);
    bus.diag_func_h = 2'd0;
    bus.diag_func_h = 2'd0;
    step();
    total++; if (bus.ebus_oe_h !== 1'b0) begin bad++; $display("FAIL conf_oe got=%b exp=0", bus.ebus_oe_h); end
    total++; if (bus.ebus_d_h !== '0) begin bad++; $display("FAIL conf_data got=%h exp=0", bus.ebus_d_h); end
    bus.diag_load_l = 1'b1;
    bus.diag_func_h = 2'd3;
    step();
    total++; if (bus.ebus_oe_h !== 1'b1) begin bad++; $display("FAIL conf_resume_oe got=%b exp=1", bus.ebus_oe_h); end
    total++; if (bus.ebus_d_h !== 4'hF) begin bad++; $display("FAIL conf_resume_data got=%h exp=f", bus.ebus_d_h); end
    bus.diag_read_l = 1'b1;
    load(3, 4'h6);
    step();
    idle();
    total++; if (bus.diag_busy_h !== 1'b1) begin bad++; $display("FAIL conf_busy got=%b exp=1", bus.diag_busy_h); end
    step();
    total++; if (bus.cram_word_h !== 16'h6005) begin bad++; $display("FAIL conf_staged got=%h exp=6005", bus.cram_word_h); end
  endtask

  task automatic test_random();
    logic [W-1:0]       mem [int];
    logic [FIELD_W-1:0] stg [NFUNC];
    logic [W-1:0]       m_word, old_word, nw;
    bit                 m_wk, old_k, m_busy, m_oe, m_dk;
    logic [FIELD_W-1:0] m_d, d;
    logic [ADDR_W-1:0]  adr;
    bit                 ld, rd;
    int                 f, a;
    for (int i = 0; i < NFUNC; i++) stg[i] = '0;
    m_busy = 0; m_wk = 0; m_oe = 0; m_d = '0; m_dk = 1;
    m_word = '0;
    idle();
    step();
    for (int n = 0; n < 400; n++) begin
      adr = ($urandom_range(0, 4) == 0) ? 11'h7FF : ADDR_W'($urandom_range(0, 15));
      ld  = ($urandom_range(0, 1) == 0);
      rd  = ($urandom_range(0, 1) == 0);
      f   = $urandom_range(0, NFUNC - 1);
      d   = FIELD_W'($urandom);
      bus.cra_adr_h   = adr;
      bus.diag_load_l = ~ld;
      bus.diag_read_l = ~rd;
      bus.diag_func_h = FSEL_W'(f);
      bus.diag_data_h = d;
      a = int'(adr);
      old_word = m_word;
      old_k    = m_wk;
      if (m_busy) begin
        nw = '0;
        for (int i = 0; i < NFUNC; i++) nw = nw | (W'(stg[i]) << (i * FIELD_W));
        mem[a] = nw;
        m_word = nw;
        m_wk   = 1;
      end else if (mem.exists(a)) begin
        m_word = mem[a];
        m_wk   = 1;
      end else begin
        m_wk = 0;
      end
      if (ld) begin
        m_oe = 0; m_d = '0; m_dk = 1;
      end else if (rd) begin
        m_oe = 1; m_d = FIELD_W'(old_word >> (f * FIELD_W)); m_dk = old_k;
      end else begin
        m_oe = 0; m_d = '0; m_dk = 1;
      end
      if (m_busy) begin
        for (int i = 0; i < NFUNC; i++) stg[i] = '0;
        m_busy = 0;
      end else if (ld) begin
        stg[f] = d;
        if (f == NFUNC - 1) m_busy = 1;
      end
      step();
      total++; if (bus.diag_busy_h !== m_busy) begin bad++; $display("FAIL rnd_busy n=%0d got=%b exp=%b", n, bus.diag_busy_h, m_busy); end
      total++; if (bus.ebus_oe_h !== m_oe) begin bad++; $display("FAIL rnd_oe n=%0d got=%b exp=%b", n, bus.ebus_oe_h, m_oe); end
      if (m_dk) begin
        total++; if (bus.ebus_d_h !== m_d) begin bad++; $display("FAIL rnd_ebus n=%0d got=%h exp=%h", n, bus.ebus_d_h, m_d); end
      end
      if (m_wk) begin
        total++; if (bus.cram_word_h !== m_word) begin bad++; $display("FAIL rnd_word n=%0d got=%h exp=%h", n, bus.cram_word_h, m_word); end
        total++; if (bus.cram_par_h !== ($countones(m_word) % 2 == 0)) begin bad++; $display("FAIL rnd_par n=%0d got=%b word=%h", n, bus.cram_par_h, m_word); end
      end
    end
    idle();
    step();
    step();
  endtask

`ifdef CRM_PARITY_CHECK_EN
  task automatic test_parity();
    idle();
    bus.cra_adr_h = 11'h020;
    dut.r_ram[32] = 17'h10000;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int f = 0; f < NFUNC; f++) begin
      load(f, FIELD_W'(f + 1));
      step();
    end
    idle();
    step();
    step();
    total++; if (bus.cram_par_err_h !== 1'b0) begin bad++; $display("FAIL par_clean got=%b exp=0", bus.cram_par_err_h); end
    dut.r_ram[32][0] = ~dut.r_ram[32][0];
    step();
    total++; if (bus.cram_word_h !== 16'h4320) begin bad++; $display("FAIL par_flip_word got=%h exp=4320", bus.cram_word_h); end
    step();
    total++; if (bus.cram_par_err_h !== 1'b1) begin bad++; $display("FAIL par_err_set got=%b exp=1", bus.cram_par_err_h); end
    bus.cra_adr_h = 11'h005;
    step();
    step();
    total++; if (bus.cram_par_err_h !== 1'b1) begin bad++; $display("FAIL par_err_sticky got=%b exp=1", bus.cram_par_err_h); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.cram_par_err_h !== 1'b0) begin bad++; $display("FAIL par_err_clear got=%b exp=0", bus.cram_par_err_h); end
    step();
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_commit_basic();
    test_partial_readback();
    test_load_during_commit();
    test_load_read_conflict();
    test_random();
`ifdef CRM_PARITY_CHECK_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/crm_slice_p.md
Name: crm_slice_p

Overview:
- Parametrised control-RAM slice: a DEPTH-word microcode store, addressed by the CRA address each cycle, with a registered microword output and an odd-parity bit.
- Diagnostics write a word as NFUNC fields, one field per load function, then read any field back onto the EBUS.
- Successor to the fixed 4-function CRAM slice: field width, field count and address width are parametrised, and it adds a staging/commit sequencer and a busy handshake.

Parameters:
- ADDR_W, 11, CRAM address width; DEPTH = 2**ADDR_W.
- NFUNC, 4, number of diag load/read fields per word, ≥1.
- FIELD_W, 4, bits per field; word width W = NFUNC*FIELD_W.
- FSEL_W = max(1, clog2(NFUNC)), derived local parameter.

Ports:
- clk_crm_h  in  1  slice clock, rising edge.
- mr_reset_l  in  1  master reset, asynchronous, active-low.
- cra_adr_h  in  ADDR_W  microword address, sampled every cycle.
- diag_load_l  in  1  load strobe, active-low, one field per cycle asserted.
- diag_read_l  in  1  readback request, active-low.
- diag_func_h  in  FSEL_W  field index for load or read.
- diag_data_h  in  FIELD_W  field data for load.
- cram_word_h  out  W  registered microword.
- cram_par_h  out  1  odd parity of cram_word_h.
- ebus_d_h  out  FIELD_W  readback field; zero when not driving.
- ebus_oe_h  out  1  readback valid/enable.
- diag_busy_h  out  1  commit in progress; loads ignored.
- cram_par_err_h  out  1  sticky parity error (see optional feature).

Behaviour:
- Reset (async, mr_reset_l=0):
  - Outputs: cram_word_h=0, ebus_d_h=0, ebus_oe_h=0, diag_busy_h=0, cram_par_err_h=0.
  - Internal: staging register=0, state=IDLE.
  - RAM contents are not cleared.
- Read path:
  - cram_word_h <= RAM[cra_adr_h] every edge; latency 1.
  - cram_par_h = ~^cram_word_h, combinational from the register, so it is 1 after reset.
- States:
  - IDLE: no fields staged.
  - STAGE: ≥1 field staged.
  - COMMIT: one-cycle write.
- Load (diag_load_l=0 and state≠COMMIT):
  - staging[f*FIELD_W +: FIELD_W] <= diag_data_h, with f=diag_func_h.
  - f ≥ NFUNC: ignored.
  - f < NFUNC-1: go to STAGE.
  - f = NFUNC-1: go to COMMIT.
- COMMIT:
  - diag_busy_h=1 for exactly this cycle.
  - RAM[cra_adr_h] <= staging, using the address present in the COMMIT cycle.
  - Staging cleared to 0; next state IDLE.
  - Fields never loaded are written as 0.
- Write-first: if the read address equals the write address in COMMIT, cram_word_h shows the new data the next cycle.
- Load strobe during COMMIT: dropped, with no staging change. The sequence must wait for diag_busy_h=0.
- Readback:
  - When diag_read_l=0 at an edge: next cycle ebus_oe_h=1 and ebus_d_h = cram_word_h field diag_func_h, taken from the current register value.
  - Held and updated each cycle while the request is asserted.
  - Release: ebus_oe_h=0 and ebus_d_h=0 the cycle after release.
- Simultaneous load and read:
  - Load wins; ebus_oe_h=0 and ebus_d_h=0 that cycle.
  - Read resumes the next cycle if still asserted.
- Read index f ≥ NFUNC: ebus_oe_h=1, ebus_d_h=0.
- Reset mid-STAGE or mid-COMMIT: staging lost. A COMMIT write is not guaranteed if reset asserts in that cycle.

Optional Feature:
- Macro: CRM_PARITY_CHECK_EN.
- Defined:
  - RAM is W+1 bits wide; COMMIT stores ~^staging as the extra bit.
  - The stored bit is registered alongside cram_word_h.
  - cram_par_err_h sets when stored parity ≠ ~^cram_word_h, and stays set until reset.
  - The first cycle after reset is not checked, because the word register holds 0 and not RAM data.
- Undefined: RAM is W bits wide; cram_par_err_h tied to 0.

Test Plan:
- Reset, then release → all outputs 0 except cram_par_h=1; diag_busy_h=0.
- adr=0x005: load f0=0x1, f1=0x2, f2=0x3, f3=0x4 → diag_busy_h=1 in the next cycle; hold adr=0x005, and cram_word_h=0x4321 with cram_par_h=0 (odd count 5 of ones → ~^ =0) the cycle after.
- adr=0x7FF: load only f3=0xF → commit; readback of f0..f3 → ebus_d_h=0x0,0x0,0x0,0xF with ebus_oe_h=1, each one cycle after its request.
- Load f1 during COMMIT cycle → ignored; the following word has f1=0 unless reloaded.
- diag_read_l and diag_load_l both low → ebus_oe_h=0 that cycle; the load is staged.
- CRM_PARITY_CHECK_EN: write 0x4321, force-flip RAM bit 0 via hierarchical deposit, read → cram_par_err_h=1 and stays 1 until mr_reset_l=0.
